// File: rtl/svo_pattern_gen.sv
// svo_pattern_gen: AXI-Stream video test-card source.
// Produces back-to-back frames of HOR_PIXELS x VER_PIXELS pixels in one of four
// patterns (HSV solid fill, colour bars, checkerboard, grey ramp). Control inputs
// are sampled at the first pixel of each frame. The fill hue steps once per frame.
//
// Ports:
//   clk, reset        pixel clock, synchronous active-high reset
//   mode              0 HSV fill, 1 bars, 2 checker, 3 grey ramp
//   sat, val          HSV saturation/value for the fill colour
//   hue_run           1 = hue advances by HUE_STEP every frame
//   out_axis_*        AXI-Stream pixel output, tdata packed {b,g,r}, tuser = SOF,
//                     tlast = end of line
//   hue               hue of the frame currently being emitted (0..359)
module svo_pattern_gen #(
    parameter int HOR_PIXELS = 640,
    parameter int VER_PIXELS = 480,
    parameter int XYBITS     = 12,
    parameter int BPC        = 8,
    parameter int HUE_STEP   = 1,
    parameter int CHECK_LOG2 = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic [7:0]         sat,
    input  logic [7:0]         val,
    input  logic               hue_run,
    output logic               out_axis_tvalid,
    input  logic               out_axis_tready,
    output logic [3*BPC-1:0]   out_axis_tdata,
    output logic               out_axis_tuser,
    output logic               out_axis_tlast,
    output logic [8:0]         hue
);

    localparam logic [XYBITS-1:0] X_LAST = XYBITS'(HOR_PIXELS - 1);
    localparam logic [XYBITS-1:0] Y_LAST = XYBITS'(VER_PIXELS - 1);
    localparam logic [XYBITS-1:0] BAR_W  = XYBITS'(HOR_PIXELS / 8);
    localparam int                GMUL_W = 25;
    localparam logic [GMUL_W-1:0] GMUL   = GMUL_W'((65536 * 256) / HOR_PIXELS);
    localparam int                GP_W   = XYBITS + GMUL_W;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgb_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SECT,
        S_VMIN,
        S_RAMP,
        S_DONE
    } hsv_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XYBITS-1:0] hcur, vcur;
    logic [1:0]        mode_l;
    logic [7:0]        sat_l, val_l;
    rgb_t              fill, fill_next;
    logic [8:0]        hue_tgt;       // hue the next frame will use
    logic              calc_req;

    hsv_state_t        st;
    logic [2:0]        sector;
    logic [5:0]        frac;
    logic [7:0]        vmin, ramp;

    // ------------------------------------------------------------------
    // Cursor decode
    // ------------------------------------------------------------------
    logic load, at_sof, at_eol, at_eof, at_lastline;

    assign load        = !out_axis_tvalid || out_axis_tready;
    assign at_sof      = (hcur == '0) && (vcur == '0);
    assign at_eol      = (hcur == X_LAST);
    assign at_eof      = at_eol && (vcur == Y_LAST);
    assign at_lastline = (hcur == '0) && (vcur == Y_LAST);

    // Frame-start pixel already uses the freshly sampled controls.
    logic [1:0] eff_mode;
    rgb_t       eff_fill;

    assign eff_mode = at_sof ? mode : mode_l;
    assign eff_fill = at_sof ? fill_next : fill;

    // ------------------------------------------------------------------
    // Hue arithmetic
    // ------------------------------------------------------------------
    logic [9:0] hue_sum;
    logic [8:0] hue_wrap;

    assign hue_sum  = 10'(hue) + 10'(HUE_STEP);
    assign hue_wrap = (hue_sum >= 10'd360) ? 9'(hue_sum - 10'd360) : hue_sum[8:0];

    // ------------------------------------------------------------------
    // Pattern generation (combinational from the cursor)
    // ------------------------------------------------------------------
    logic [XYBITS-1:0] bar_raw;
    logic [2:0]        bar_idx;
    logic [2:0]        bar_rgb;       // {r,g,b} on/off
    logic              tile;
    logic [GP_W-1:0]   gprod, gshift;
    logic [7:0]        gray;
    rgb_t              pix;

    assign bar_raw = hcur / BAR_W;
    // The last bar absorbs any remainder when HOR_PIXELS is not a multiple of 8.
    assign bar_idx = (bar_raw > XYBITS'(7)) ? 3'd7 : bar_raw[2:0];

    always_comb begin
        bar_rgb = 3'b000;
        case (bar_idx)
            3'd0:    bar_rgb = 3'b111;  // white
            3'd1:    bar_rgb = 3'b110;  // yellow
            3'd2:    bar_rgb = 3'b011;  // cyan
            3'd3:    bar_rgb = 3'b010;  // green
            3'd4:    bar_rgb = 3'b101;  // magenta
            3'd5:    bar_rgb = 3'b100;  // red
            3'd6:    bar_rgb = 3'b001;  // blue
            default: bar_rgb = 3'b000;  // black
        endcase
    end

    assign tile   = hcur[CHECK_LOG2] ^ vcur[CHECK_LOG2];
    assign gprod  = GP_W'(hcur) * GP_W'(GMUL);
    assign gshift = gprod >> 16;
    assign gray   = (gshift > GP_W'(255)) ? 8'hFF : gshift[7:0];

    always_comb begin
        pix = '0;
        case (eff_mode)
            2'd0:    pix = eff_fill;
            2'd1:    pix = {{8{bar_rgb[0]}}, {8{bar_rgb[1]}}, {8{bar_rgb[2]}}};
            2'd2:    pix = tile ? eff_fill : '0;
            default: pix = {gray, gray, gray};
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers, cursors, frame-start sampling, hue
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_axis_tvalid <= 1'b0;
            out_axis_tdata  <= '0;
            out_axis_tuser  <= 1'b0;
            out_axis_tlast  <= 1'b0;
            hcur            <= '0;
            vcur            <= '0;
            mode_l          <= '0;
            sat_l           <= '0;
            val_l           <= '0;
            fill            <= '0;
            hue             <= '0;
            hue_tgt         <= '0;
        end else if (load) begin
            out_axis_tvalid <= 1'b1;
            out_axis_tdata  <= {pix.b[7 -: BPC], pix.g[7 -: BPC], pix.r[7 -: BPC]};
            out_axis_tuser  <= at_sof;
            out_axis_tlast  <= at_eol;

            if (at_sof) begin
                mode_l <= mode;
                sat_l  <= sat;
                val_l  <= val;
                fill   <= fill_next;
            end

            // hue_run is taken when the last line starts so the next frame's
            // fill colour is finished before its first pixel loads, even when
            // the sink never stalls.
            if (at_lastline)
                hue_tgt <= hue_run ? hue_wrap : hue;

            if (at_eof)
                hue <= hue_tgt;

            if (at_eol) begin
                hcur <= '0;
                vcur <= (vcur == Y_LAST) ? '0 : vcur + 1'b1;
            end else begin
                hcur <= hcur + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // HSV -> RGB conversion of hue_tgt with the latched sat/val
    // ------------------------------------------------------------------
    logic [15:0] vmin_prod;
    logic [7:0]  span;
    logic [13:0] ramp_prod;
    logic [7:0]  v_up, v_dn;

    assign vmin_prod = 16'(val_l) * (16'd256 - 16'(sat_l));
    assign span      = val_l - vmin;
    assign ramp_prod = 14'(span) * 14'(frac);
    assign v_up      = vmin + ramp;
    assign v_dn      = val_l - ramp;

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= S_IDLE;
            calc_req  <= 1'b1;   // compute a fill straight after reset
            sector    <= '0;
            frac      <= '0;
            vmin      <= '0;
            ramp      <= '0;
            fill_next <= '0;
        end else begin
            if (load && at_lastline)
                calc_req <= 1'b1;
            else if (st == S_IDLE && calc_req)
                calc_req <= 1'b0;

            case (st)
                S_IDLE: if (calc_req) st <= S_SECT;
                S_SECT: begin
                    sector <= 3'(hue_tgt / 9'd60);
                    frac   <= 6'(hue_tgt % 9'd60);
                    st     <= S_VMIN;
                end
                S_VMIN: begin
                    vmin <= 8'(vmin_prod >> 8);
                    st   <= S_RAMP;
                end
                S_RAMP: begin
                    ramp <= 8'(ramp_prod / 14'd60);
                    st   <= S_DONE;
                end
                S_DONE: begin
                    case (sector)
                        3'd0:    fill_next <= '{r: val_l, g: v_up,  b: vmin};
                        3'd1:    fill_next <= '{r: v_dn,  g: val_l, b: vmin};
                        3'd2:    fill_next <= '{r: vmin,  g: val_l, b: v_up};
                        3'd3:    fill_next <= '{r: vmin,  g: v_dn,  b: val_l};
                        3'd4:    fill_next <= '{r: v_up,  g: vmin,  b: val_l};
                        default: fill_next <= '{r: val_l, g: vmin,  b: v_dn};
                    endcase
                    st <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_svo_pattern_gen.sv
// Testbench for svo_pattern_gen: directed sequences, a table of pattern vectors
// and a randomized phase, all cross-checked against a frame-level reference model.
module tb_svo_pattern_gen;

    localparam int H    = 16;
    localparam int V    = 4;
    localparam int BPC  = 8;
    localparam int STEP = 7;
    localparam int CL2  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [7:0]  sat = 8'd0, val = 8'd0;
    logic        hue_run = 1'b0;
    logic        tready = 1'b1;
    logic        tvalid, tuser, tlast;
    logic [23:0] tdata;
    logic [8:0]  hue;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    svo_pattern_gen #(
        .HOR_PIXELS(H), .VER_PIXELS(V), .XYBITS(12), .BPC(BPC),
        .HUE_STEP(STEP), .CHECK_LOG2(CL2)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .sat(sat), .val(val),
        .hue_run(hue_run),
        .out_axis_tvalid(tvalid), .out_axis_tready(tready),
        .out_axis_tdata(tdata), .out_axis_tuser(tuser), .out_axis_tlast(tlast),
        .hue(hue)
    );

    // ---------------- reference model ----------------
    function automatic logic [23:0] hsv(int h, int s, int v);
        int sec, f, vmin, a, r, g, b;
        sec  = h / 60;
        f    = h % 60;
        vmin = (v * (256 - s)) / 256;
        a    = ((v - vmin) * f) / 60;
        case (sec)
            0:       begin r = v;        g = vmin + a; b = vmin;     end
            1:       begin r = v - a;    g = v;        b = vmin;     end
            2:       begin r = vmin;     g = v;        b = vmin + a; end
            3:       begin r = vmin;     g = v - a;    b = v;        end
            4:       begin r = vmin + a; g = vmin;     b = v;        end
            default: begin r = v;        g = vmin;     b = v - a;    end
        endcase
        return {8'(b), 8'(g), 8'(r)};
    endfunction

    function automatic logic [23:0] pattern(int m, int x, int y, logic [23:0] fill);
        int idx, gv;
        case (m)
            0: return fill;
            1: begin
                idx = x / (H / 8);
                if (idx > 7) idx = 7;
                case (idx)
                    0: return 24'hFFFFFF;
                    1: return 24'h00FFFF;
                    2: return 24'hFFFF00;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'h0000FF;
                    6: return 24'hFF0000;
                    default: return 24'h000000;
                endcase
            end
            2: return ((((x >> CL2) ^ (y >> CL2)) & 1) != 0) ? fill : 24'h0;
            default: begin
                gv = (x * ((65536 * 256) / H)) >> 16;
                if (gv > 255) gv = 255;
                return {3{8'(gv)}};
            end
        endcase
    endfunction

    typedef struct {
        bit          valid;
        logic [23:0] data;
        bit          user;
        bit          last;
        int          pix;      // index of the next pixel to be loaded in the frame
        int          hue;
        int          tgt;      // hue decided at the start of the last line
        int          mode_l, sat_l, val_l;
        logic [23:0] fill;
        bit          first;    // first frame after reset has a black fill
    } mdl_t;

    function automatic mdl_t mdl_step(mdl_t m, bit rst, bit rdy, int md, int s, int v, bit run);
        mdl_t n;
        int x, y;
        n = m;
        if (rst) begin
            n.valid = 0; n.data = 0; n.user = 0; n.last = 0; n.pix = 0;
            n.hue = 0; n.tgt = 0; n.mode_l = 0; n.sat_l = 0; n.val_l = 0;
            n.fill = 0; n.first = 1;
            return n;
        end
        if (m.valid && !rdy) return n;
        x = m.pix % H;
        y = m.pix / H;
        if (m.pix == 0) begin
            n.fill   = m.first ? 24'h0 : hsv(m.hue, m.sat_l, m.val_l);
            n.first  = 0;
            n.mode_l = md; n.sat_l = s; n.val_l = v;
        end
        if (x == 0 && y == V - 1) n.tgt = run ? (m.hue + STEP) % 360 : m.hue;
        n.valid = 1;
        n.data  = pattern(n.mode_l, x, y, n.fill);
        n.user  = (m.pix == 0);
        n.last  = (x == H - 1);
        if (m.pix == H * V - 1) n.hue = n.tgt;
        n.pix = (m.pix + 1) % (H * V);
        return n;
    endfunction

    mdl_t m;
    bit   armed = 0;

    always @(posedge clk) begin
        m <= mdl_step(m, reset, tready, int'(mode), int'(sat), int'(val), hue_run);
        if (reset) armed <= 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if (tvalid !== m.valid || tdata !== m.data || tuser !== m.user ||
                tlast !== m.last || int'(hue) != m.hue) begin
                failures++;
                $display("FAIL model t=%0t valid %b/%b data %h/%h user %b/%b last %b/%b hue %0d/%0d",
                         $time, tvalid, m.valid, tdata, m.data, tuser, m.user,
                         tlast, m.last, hue, m.hue);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Returns the next beat that transfers on the coming edge.
    task automatic wait_beat(output logic [23:0] d, output logic u, output logic l);
        bit got;
        got = 0;
        d = '0; u = 0; l = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (tvalid && tready) begin
                d = tdata; u = tuser; l = tlast; got = 1;
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL wait_beat timeout got=none exp=beat");
        end
    endtask

    task automatic wait_sof(output logic [23:0] d);
        logic u, l;
        u = 0;
        d = '0;
        for (int i = 0; i < 200 && !u; i++) wait_beat(d, u, l);
        if (!u) begin
            checks++; failures++;
            $display("FAIL wait_sof timeout got=none exp=tuser");
        end
    endtask

    typedef struct {
        int          md;
        int          x;
        logic [23:0] exp;
    } vec_t;

    vec_t        tbl[14];
    logic [23:0] row_bars[H];
    logic [23:0] row_grey[H];

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [23:0] d;
        logic        u, l;
        int          prev;
        bit          found;

        tbl[0]  = '{1, 0,  24'hFFFFFF};
        tbl[1]  = '{1, 1,  24'hFFFFFF};
        tbl[2]  = '{1, 2,  24'h00FFFF};
        tbl[3]  = '{1, 4,  24'hFFFF00};
        tbl[4]  = '{1, 6,  24'h00FF00};
        tbl[5]  = '{1, 8,  24'hFF00FF};
        tbl[6]  = '{1, 10, 24'h0000FF};
        tbl[7]  = '{1, 12, 24'hFF0000};
        tbl[8]  = '{1, 14, 24'h000000};
        tbl[9]  = '{1, 15, 24'h000000};
        tbl[10] = '{3, 0,  24'h000000};
        tbl[11] = '{3, 1,  24'h101010};
        tbl[12] = '{3, 8,  24'h808080};
        tbl[13] = '{3, 15, 24'hF0F0F0};

        // reset state
        repeat (3) @(negedge clk);
        sat = 8'd255; val = 8'd255; mode = 2'd0;
        check("rst_outputs", {5'b0, tvalid, tdata, tuser, tlast}, 32'h0);
        check("rst_hue", {23'b0, hue}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("first_beat_valid_sof", {30'b0, tvalid, tuser}, 32'd3);

        // framing: tuser on beat 0 of 64, tlast every 16th
        for (int b = 1; b < 2 * H * V; b++) begin
            wait_beat(d, u, l);
            check("frame_flags", {30'b0, u, l},
                  {30'b0, (b % (H * V)) == 0, (b % H) == H - 1});
            if (b == H * V) check("fill_hue0", {8'b0, d}, 32'h0000FF);
        end

        // capture one row of bars and of the grey ramp, then walk the table
        mode = 2'd1;
        wait_sof(d);
        row_bars[0] = d;
        for (int x = 1; x < H; x++) begin wait_beat(d, u, l); row_bars[x] = d; end
        mode = 2'd3;
        wait_sof(d);
        row_grey[0] = d;
        for (int x = 1; x < H; x++) begin wait_beat(d, u, l); row_grey[x] = d; end
        for (int i = 0; i < 14; i++)
            check($sformatf("table_m%0d_x%0d", tbl[i].md, tbl[i].x),
                  {8'b0, (tbl[i].md == 1) ? row_bars[tbl[i].x] : row_grey[tbl[i].x]},
                  {8'b0, tbl[i].exp});

        // stall mid-line: x=7 goes, x=8 is held for 5 cycles
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            wait_beat(d, u, l);
            if (d == 24'h707070) found = 1;
        end
        check("stall_find_x7", {31'b0, found}, 32'd1);
        @(negedge clk);
        tready = 1'b0;
        check("stall_x8_present", {8'b0, tdata}, 32'h808080);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", {5'b0, tvalid, tdata, tuser, tlast}, {5'b0, 1'b1, 24'h808080, 2'b00});
        end
        tready = 1'b1;
        check("stall_next_x8", {8'b0, tdata}, 32'h808080);
        wait_beat(d, u, l);
        check("stall_then_x9", {8'b0, d}, 32'h909090);

        // mode change 1 -> 0 at (5,2): frame stays bars, next frame is fill
        mode = 2'd1;
        wait_sof(d);
        for (int b = 1; b <= 2 * H + 5; b++) wait_beat(d, u, l);
        mode = 2'd0;
        for (int b = 2 * H + 6; b < H * V; b++) begin
            wait_beat(d, u, l);
            check("bars_tail", {8'b0, d}, {8'b0, pattern(1, b % H, 0, 24'h0)});
        end
        wait_beat(d, u, l);
        check("switch_sof", {31'b0, u}, 32'd1);
        check("switch_fill", {8'b0, d}, 32'h0000FF);

        // hue wrap 357 + 7 -> 4
        hue_run = 1'b1;
        prev = -1;
        found = 0;
        for (int f = 0; f < 80 && !found; f++) begin
            wait_sof(d);
            if (prev == 357) begin
                check("hue_wrap", {23'b0, hue}, 32'd4);
                check("hue4_fill", {8'b0, d}, 32'h0011FF);
                found = 1;
            end
            prev = int'(hue);
        end
        check("hue_reached_357", {31'b0, found}, 32'd1);
        hue_run = 1'b0;

        // randomized phase, checked by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            tready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 39) == 0) sat = 8'($urandom);
            if ($urandom_range(0, 39) == 0) val = 8'($urandom);
            if ($urandom_range(0, 149) == 0) hue_run = ~hue_run;
            reset = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        reset = 1'b0; tready = 1'b1; hue_run = 1'b0;

        // reset at (9,1) for one cycle
        mode = 2'd3;
        wait_sof(d);
        wait_sof(d);
        for (int b = 1; b <= H + 9; b++) wait_beat(d, u, l);
        check("pre_reset_x9", {8'b0, d}, 32'h909090);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs", {5'b0, tvalid, tdata, tuser, tlast}, 32'h0);
        check("mid_reset_hue", {23'b0, hue}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_beat", {5'b0, tvalid, tdata, tuser, tlast}, {5'b0, 1'b1, 24'h0, 2'b10});
        check("post_reset_hue", {23'b0, hue}, 32'd0);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
